mem_bus_responder: RTL and testbench



---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_word_ram.sv | 44 ++++
 rtl/mem_bus_responder.sv | 152 +++++++++++++++
 tb/tb_mem_bus_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus responder: bus widths, FSM state
// encoding, error-flag encoding and the request address check.
package bus_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

  localparam logic ERR_OK    = 1'b0;
  localparam logic ERR_FAULT = 1'b1;

  // A request faults when it is not word aligned or its word index falls
  // past the end of the array.
  function automatic logic addr_is_bad(input logic [BUS_ADDR_W-1:0] addr,
                                       input int depth_words);
    logic [BUS_ADDR_W-1:0] word_idx;
    word_idx = {2'b00, addr[BUS_ADDR_W-1:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= BUS_ADDR_W'(depth_words));
  endfunction

endpackage

// File: rtl/bus_word_ram.sv
// Word-wide storage array for the memory bus responder.
// Ports:
//   clk    - clock, all activity on the rising edge
//   en     - perform an access this edge
//   we     - write enable (qualified by en)
//   idx    - word index
//   wdata  - write data
//   rdata  - registered read data; on a write it returns the new value
// Contents are never reset.
module bus_word_ram
  import bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_W      = BUS_DATA_W,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = we ? wdata : mem[idx];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Word-addressed memory responder with a fixed number of wait states.
// Accepts one request at a time, performs the access on the edge that
// enters RESP and issues a one-cycle response pulse.
// Ports:
//   clk            - clock
//   reset          - asynchronous active-low reset
//   io_req_valid   - request present
//   io_req_we      - 1 = write, 0 = read
//   io_req_addr    - byte address
//   io_req_wdata   - write data
//   io_req_ready   - responder is idle and will accept a request
//   io_resp_valid  - one-cycle response pulse
//   io_resp_rdata  - read data (or written value), held until next response
//   io_resp_err    - misaligned / out-of-range flag, held until next response
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | ready; accept and capture a request
// ST_WAIT | counting down wait states, inputs ignored
// ST_RESP | response pulse, access already performed on entry
module mem_bus_responder
  import bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_req_valid,
  input  logic                  io_req_we,
  input  logic [BUS_ADDR_W-1:0] io_req_addr,
  input  logic [BUS_DATA_W-1:0] io_req_wdata,
  output logic                  io_req_ready,
  output logic                  io_resp_valid,
  output logic [BUS_DATA_W-1:0] io_resp_rdata,
  output logic                  io_resp_err
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  bus_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [BUS_ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [BUS_DATA_W-1:0] rdata_q, rdata_d;

  logic                  enter_resp;
  logic                  op_we;
  logic [BUS_ADDR_W-1:0] op_addr;
  logic [BUS_DATA_W-1:0] op_wdata;
  logic                  op_err;
  logic [BUS_DATA_W-1:0] ram_rdata;
  logic [BUS_DATA_W-1:0] resp_rdata;

  // With zero wait states the access happens on the acceptance edge, so the
  // operation must come straight from the request inputs rather than the
  // capture registers.
  assign op_we    = (state_q == ST_IDLE) ? io_req_we    : we_q;
  assign op_addr  = (state_q == ST_IDLE) ? io_req_addr  : addr_q;
  assign op_wdata = (state_q == ST_IDLE) ? io_req_wdata : wdata_q;
  assign op_err   = addr_is_bad(op_addr, DEPTH_WORDS);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io_req_valid) begin
          we_d    = io_req_we;
          addr_d  = io_req_addr;
          wdata_d = io_req_wdata;
          cnt_d   = WAIT_LOAD;
          if (WAIT_LOAD == 4'd0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        rdata_d = resp_rdata;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (enter_resp) begin
      err_d = op_err ? ERR_FAULT : ERR_OK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= ERR_OK;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // The storage has no reset, so its enable is also gated by reset: a reset
  // landing on the edge that would enter RESP must not commit the write.
  bus_word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_W     (BUS_DATA_W)
  ) u_ram (
    .clk  (clk),
    .en   (enter_resp & reset),
    .we   (op_we & ~op_err),
    .idx  (op_addr[IDX_W+1:2]),
    .wdata(op_wdata),
    .rdata(ram_rdata)
  );

  // During RESP the fresh RAM output is shown directly; afterwards the value
  // latched on the way out of RESP holds it until the next response.
  assign resp_rdata    = (err_q == ERR_FAULT) ? '0 : ram_rdata;
  assign io_req_ready  = (state_q == ST_IDLE);
  assign io_resp_valid = (state_q == ST_RESP);
  assign io_resp_rdata = (state_q == ST_RESP) ? resp_rdata : rdata_q;
  assign io_resp_err   = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

  localparam int I_W1 = 0;
  localparam int I_W0 = 1;
  localparam int I_W3 = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset),
    .io_req_valid(req_valid[I_W1]), .io_req_we(req_we[I_W1]),
    .io_req_addr(req_addr[I_W1]), .io_req_wdata(req_wdata[I_W1]),
    .io_req_ready(req_ready[I_W1]), .io_resp_valid(resp_valid[I_W1]),
    .io_resp_rdata(resp_rdata[I_W1]), .io_resp_err(resp_err[I_W1])
  );

  mem_bus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset),
    .io_req_valid(req_valid[I_W0]), .io_req_we(req_we[I_W0]),
    .io_req_addr(req_addr[I_W0]), .io_req_wdata(req_wdata[I_W0]),
    .io_req_ready(req_ready[I_W0]), .io_resp_valid(resp_valid[I_W0]),
    .io_resp_rdata(resp_rdata[I_W0]), .io_resp_err(resp_err[I_W0])
  );

  mem_bus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset),
    .io_req_valid(req_valid[I_W3]), .io_req_we(req_we[I_W3]),
    .io_req_addr(req_addr[I_W3]), .io_req_wdata(req_wdata[I_W3]),
    .io_req_ready(req_ready[I_W3]), .io_resp_valid(resp_valid[I_W3]),
    .io_resp_rdata(resp_rdata[I_W3]), .io_resp_err(resp_err[I_W3])
  );

  // Issue one request on instance d and wait for its response. lat counts
  // cycles from the acceptance edge to the response cycle (-1 on timeout);
  // rdy_bad flags io_req_ready seen high before or during the response.
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic scramble,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output logic rdy_bad);
    rdata = '0;
    err = 1'b0;
    lat = 0;
    rdy_bad = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready[d]; i++) @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    if (scramble) begin
      req_we[d]    = ~we;
      req_addr[d]  = ~addr;
      req_wdata[d] = ~wdata;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (req_ready[d]) rdy_bad = 1'b1;
      if (resp_valid[d]) begin
        rdata = resp_rdata[d];
        err = resp_err[d];
        return;
      end
    end
    lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end
    for (int c = 0; c < 3; c++) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL rst_ready[%0d]: got %b expected 1", d, req_ready[d]); end
      checks++; if (resp_valid[d] !== 1'b0) begin errors++; $display("FAIL rst_valid[%0d]: got %b expected 0", d, resp_valid[d]); end
      checks++; if (resp_rdata[d] !== 32'h0) begin errors++; $display("FAIL rst_rdata[%0d]: got %h expected 0", d, resp_rdata[d]); end
      checks++; if (resp_err[d] !== 1'b0) begin errors++; $display("FAIL rst_err[%0d]: got %b expected 0", d, resp_err[d]); end
    end
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL post_rst_ready[%0d]: got %b expected 1", d, req_ready[d]); end
      checks++; if (resp_valid[d] !== 1'b0) begin errors++; $display("FAIL post_rst_valid[%0d]: got %b expected 0", d, resp_valid[d]); end
      checks++; if (resp_rdata[d] !== 32'h0) begin errors++; $display("FAIL post_rst_rdata[%0d]: got %h expected 0", d, resp_rdata[d]); end
      checks++; if (resp_err[d] !== 1'b0) begin errors++; $display("FAIL post_rst_err[%0d]: got %b expected 0", d, resp_err[d]); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        rb;
    do_req(I_W1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat, rb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", er); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rdata: got %h expected deadbeef", rd); end
    checks++; if (rb !== 1'b0) begin errors++; $display("FAIL wr_ready_low: ready seen high while busy"); end
    @(negedge clk);
    checks++; if (resp_valid[I_W1] !== 1'b0) begin errors++; $display("FAIL resp_pulse_width: got %b expected 0", resp_valid[I_W1]); end
    checks++; if (resp_rdata[I_W1] !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h expected deadbeef", resp_rdata[I_W1]); end
    checks++; if (req_ready[I_W1] !== 1'b1) begin errors++; $display("FAIL ready_after_resp: got %b expected 1", req_ready[I_W1]); end
    do_req(I_W1, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, rb);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", er); end
  endtask

  task automatic test_latency();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        rb;
    do_req(I_W0, 1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat, rb);
    checks++; if (lat !== 1) begin errors++; $display("FAIL lat_w0: got %0d expected 1", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lat_w0_err: got %b expected 0", er); end
    checks++; if (rb !== 1'b0) begin errors++; $display("FAIL lat_w0_ready_low: ready seen high while busy"); end
    do_req(I_W3, 1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat, rb);
    checks++; if (lat !== 4) begin errors++; $display("FAIL lat_w3: got %0d expected 4", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lat_w3_err: got %b expected 0", er); end
    checks++; if (rb !== 1'b0) begin errors++; $display("FAIL lat_w3_ready_low: ready seen high while busy"); end
    do_req(I_W0, 1'b1, 32'h44, 32'hCAFEF00D, 1'b0, rd, er, lat, rb);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL w0_wr_rdata: got %h expected cafef00d", rd); end
    do_req(I_W0, 1'b0, 32'h44, 32'h0, 1'b0, rd, er, lat, rb);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL w0_rd_rdata: got %h expected cafef00d", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        rb;
    do_req(I_W1, 1'b1, 32'h13, 32'h11111111, 1'b0, rd, er, lat, rb);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h expected 0", rd); end
    do_req(I_W1, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, rb);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL misalign_no_write: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL err_clears: got %b expected 0", er); end
    do_req(I_W1, 1'b0, 32'h1000, 32'h0, 1'b0, rd, er, lat, rb);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h expected 0", rd); end
    do_req(I_W1, 1'b1, 32'hFFC, 32'h0BADF00D, 1'b0, rd, er, lat, rb);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_err: got %b expected 0", er); end
    do_req(I_W1, 1'b0, 32'hFFC, 32'h0, 1'b0, rd, er, lat, rb);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL last_word_rdata: got %h expected 0badf00d", rd); end
    do_req(I_W1, 1'b1, 32'h1000, 32'h22222222, 1'b0, rd, er, lat, rb);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_write_err: got %b expected 1", er); end
    do_req(I_W1, 1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat, rb);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word0_err: got %b expected 0", er); end
    checks++; if (rd === 32'h22222222) begin errors++; $display("FAIL oor_write_aliased: got %h expected not 22222222", rd); end
  endtask

  task automatic test_hold_abort();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        rb;
    logic        seen;
    do_req(I_W3, 1'b1, 32'h20, 32'h1234, 1'b1, rd, er, lat, rb);
    checks++; if (lat !== 4) begin errors++; $display("FAIL hold_latency: got %0d expected 4", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL hold_err: got %b expected 0", er); end
    checks++; if (rd !== 32'h1234) begin errors++; $display("FAIL hold_rdata: got %h expected 1234", rd); end
    do_req(I_W3, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, rb);
    checks++; if (rd !== 32'h1234) begin errors++; $display("FAIL hold_readback: got %h expected 1234", rd); end
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready[I_W3]; i++) @(negedge clk);
    req_valid[I_W3] = 1'b1;
    req_we[I_W3]    = 1'b1;
    req_addr[I_W3]  = 32'h20;
    req_wdata[I_W3] = 32'h5678;
    @(posedge clk);
    #1;
    req_valid[I_W3] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (req_ready[I_W3] !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", req_ready[I_W3]); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid[I_W3]) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_resp: got response, expected none"); end
    do_req(I_W3, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, rb);
    checks++; if (rd !== 32'h1234) begin errors++; $display("FAIL abort_no_write: got %h expected 1234", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL abort_read_err: got %b expected 0", er); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int rdy_cnt;
    int first;
    pulses = 0;
    rdy_cnt = 0;
    first = -1;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready[I_W1]; i++) @(negedge clk);
    req_valid[I_W1] = 1'b1;
    req_we[I_W1]    = 1'b0;
    req_addr[I_W1]  = 32'h10;
    req_wdata[I_W1] = 32'h0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (resp_valid[I_W1]) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (req_ready[I_W1]) rdy_cnt++;
    end
    req_valid[I_W1] = 1'b0;
    checks++; if (first !== 2) begin errors++; $display("FAIL b2b_first_resp: got %0d expected 2", first); end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
    checks++; if (rdy_cnt !== 3) begin errors++; $display("FAIL b2b_ready_cycles: got %0d expected 3", rdy_cnt); end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency();
    test_errors();
    test_hold_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
